// File: rtl/wb_cmd_arbiter.sv
// Shares one Wishbone command port (cmd_word + o_stb) among NREQ requesters with setup/strobe/gap framing.
// Optional macro WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the lowest index wins.
module wb_cmd_arbiter #(
    parameter int NREQ           = 4,
    parameter int STB_CYCLES     = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [34*NREQ-1:0]   req_cmd,
    input  logic                 i_ack,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 o_stb,
    output logic [33:0]          cmd_word,
    output logic                 busy,
    output logic                 timeout,
    output logic                 timeout_sticky
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int STB_W  = $clog2(STB_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STB, S_WAIT, S_GAP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_done;
    logic                r_o_stb;
    logic [33:0]         r_cmd_word;
    logic                r_busy;
    logic                r_timeout;
    logic                r_timeout_sticky;
    logic                r_ack_seen;
    logic [STB_W-1:0]    r_stb_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic                w_load;
    logic                w_complete;
    logic                w_expire;
    logic                w_ack_any;
    logic                w_wait_last;
    logic [IDX_W-1:0]    w_win_idx;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    r_rr_ptr;

    // Scan downward so the asserted index closest after the pointer is written last and wins.
    always_comb begin
        w_win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(r_rr_ptr) + i) % NREQ]) begin
                w_win_idx = IDX_W'((int'(r_rr_ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + 1'b1;
        end
    end
`else
    always_comb begin
        w_win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_complete   = 1'b0;
        w_expire     = 1'b0;
        w_ack_any    = i_ack | r_ack_seen;
        w_wait_last  = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_load       = 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: w_state_next = S_STB;
            S_STB: begin
                if (r_stb_cnt == STB_W'(STB_CYCLES - 1)) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the expiry cycle wins over the timeout.
                if (w_ack_any || w_wait_last) begin
                    w_complete   = 1'b1;
                    w_expire     = ~w_ack_any;
                    w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt >= GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant          <= '0;
            r_done           <= '0;
            r_o_stb          <= 1'b0;
            r_cmd_word       <= '0;
            r_busy           <= 1'b0;
            r_timeout        <= 1'b0;
            r_timeout_sticky <= 1'b0;
            r_ack_seen       <= 1'b0;
            r_stb_cnt        <= '0;
            r_wait_cnt       <= '0;
            r_gap_cnt        <= '0;
        end else begin
            r_o_stb   <= (w_state_next == S_STB);
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= w_complete ? r_grant : '0;
            r_timeout <= w_expire;
            if (w_expire) begin
                r_timeout_sticky <= 1'b1;
            end
            if (w_load) begin
                r_grant    <= NREQ'(1) << w_win_idx;
                r_cmd_word <= req_cmd[34*int'(w_win_idx) +: 34];
                r_ack_seen <= 1'b0;
            end else begin
                if (w_complete) begin
                    r_grant <= '0;
                end
                if (r_state == S_STB && i_ack) begin
                    r_ack_seen <= 1'b1;
                end
            end
            // Phase counters restart whenever their state is left and saturate at their limit.
            if (r_state == S_STB && w_state_next == S_STB) begin
                if (r_stb_cnt != STB_W'(STB_CYCLES)) r_stb_cnt <= r_stb_cnt + 1'b1;
            end else begin
                r_stb_cnt <= '0;
            end
            if (r_state == S_WAIT && w_state_next == S_WAIT) begin
                if (r_wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_state == S_GAP && w_state_next == S_GAP) begin
                if (r_gap_cnt != GAP_W'(GAP_CYCLES)) r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign grant          = r_grant;
    assign done           = r_done;
    assign o_stb          = r_o_stb;
    assign cmd_word       = r_cmd_word;
    assign busy           = r_busy;
    assign timeout        = r_timeout;
    assign timeout_sticky = r_timeout_sticky;

endmodule

// File: tb/tb_wb_cmd_arbiter.sv
// Bench for wb_cmd_arbiter (NREQ=4, STB=2, GAP=1, TIMEOUT=8); round-robin test built with WB_ARB_ROUND_ROBIN_EN.
module tb_wb_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [135:0] req_cmd;
    logic         i_ack;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         o_stb;
    logic [33:0]  cmd_word;
    logic         busy;
    logic         timeout;
    logic         timeout_sticky;

    int n_vec = 0;
    int n_err = 0;
    logic [37:0] exp_q[$];

    wb_cmd_arbiter #(
        .NREQ(4), .STB_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .i_ack(i_ack),
        .grant(grant), .done(done), .o_stb(o_stb), .cmd_word(cmd_word),
        .busy(busy), .timeout(timeout), .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ack responder + done monitor. mode 0: ack on first WAIT cycle; 1: ack in 2nd STB cycle; 2: never.
    task automatic run_cmd(input int mode, input int limit, output int cyc, output int stb_len,
                           output int first_stb, output logic [3:0] d, output logic [33:0] cw,
                           output logic to);
        logic prev_stb;
        prev_stb  = 1'b0;
        cyc       = 0;
        stb_len   = 0;
        first_stb = -1;
        d         = '0;
        cw        = '0;
        to        = 1'b0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            i_ack = 1'b0;
            if (o_stb) begin
                stb_len++;
                if (first_stb < 0) first_stb = cyc;
            end
            if (done != 4'b0) begin
                d  = done;
                cw = cmd_word;
                to = timeout;
                break;
            end
            if (mode == 0 && prev_stb && !o_stb) i_ack = 1'b1;
            if (mode == 1 && o_stb && stb_len == 2) i_ack = 1'b1;
            prev_stb = o_stb;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_cmd = '0; i_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
        n_vec++; if (o_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", o_stb); end
        n_vec++; if (cmd_word !== 34'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", cmd_word); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({timeout, timeout_sticky} !== 2'b00) begin n_err++; $display("FAIL reset_timeout: got %b want 00", {timeout, timeout_sticky}); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [37:0] e;
        req_cmd[33:0] = 34'h200000001;
        req = 4'b0001;
        exp_q.push_back({4'b0001, 34'h200000001});
        @(negedge clk);
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", grant); end
        n_vec++; if (cmd_word !== 34'h200000001) begin n_err++; $display("FAIL single_cmd: got %h want 200000001", cmd_word); end
        n_vec++; if ({o_stb, busy} !== 2'b01) begin n_err++; $display("FAIL single_setup: got stb/busy %b want 01", {o_stb, busy}); end
        req_cmd[33:0] = 34'h0DEADBEEF;
        @(negedge clk);
        n_vec++; if (o_stb !== 1'b1) begin n_err++; $display("FAIL single_stb_c2: got %b want 1", o_stb); end
        @(negedge clk);
        n_vec++; if (o_stb !== 1'b1) begin n_err++; $display("FAIL single_stb_c3: got %b want 1", o_stb); end
        @(negedge clk);
        n_vec++; if (o_stb !== 1'b0) begin n_err++; $display("FAIL single_stb_c4: got %b want 0", o_stb); end
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        e = exp_q.pop_front();
        n_vec++; if (done !== e[37:34]) begin n_err++; $display("FAIL single_done: got %b want %b", done, e[37:34]); end
        n_vec++; if (cmd_word !== e[33:0]) begin n_err++; $display("FAIL single_cmd_hold: got %h want %h", cmd_word, e[33:0]); end
        n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL single_gap_grant: got %b want 0000", grant); end
        req = 4'b0;
        @(negedge clk);
        n_vec++; if ({done, busy} !== 5'b0) begin n_err++; $display("FAIL single_idle: got done/busy %b want 00000", {done, busy}); end
    endtask

    task automatic test_priority();
        int cyc, sl, fs;
        logic [3:0] d;
        logic [33:0] cw;
        logic to;
        logic [37:0] e;
        req_cmd[34*1 +: 34] = 34'h0AAAA;
        req_cmd[34*3 +: 34] = 34'h3BBBB;
        req = 4'b1010;
        exp_q.push_back({4'b0010, 34'h0AAAA});
        exp_q.push_back({4'b1000, 34'h3BBBB});
        for (int k = 0; k < 2; k++) begin
            run_cmd(0, 40, cyc, sl, fs, d, cw, to);
            e = exp_q.pop_front();
            n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL prio_done%0d: got %b want %b", k, d, e[37:34]); end
            n_vec++; if (cw !== e[33:0]) begin n_err++; $display("FAIL prio_cmd%0d: got %h want %h", k, cw, e[33:0]); end
            n_vec++; if (cyc != 5) begin n_err++; $display("FAIL prio_latency%0d: got %0d want 5", k, cyc); end
            req = req & ~e[37:34];
            @(negedge clk);
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL prio_idle%0d: got %b want 0", k, busy); end
        end
    endtask

    task automatic test_early_ack();
        int cyc, sl, fs;
        logic [3:0] d;
        logic [33:0] cw;
        logic to;
        logic [37:0] e;
        req_cmd[33:0] = 34'h155555555;
        req = 4'b0001;
        exp_q.push_back({4'b0001, 34'h155555555});
        run_cmd(1, 40, cyc, sl, fs, d, cw, to);
        e = exp_q.pop_front();
        n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL early_done: got %b want %b", d, e[37:34]); end
        n_vec++; if (cw !== e[33:0]) begin n_err++; $display("FAIL early_cmd: got %h want %h", cw, e[33:0]); end
        n_vec++; if (sl != 2) begin n_err++; $display("FAIL early_stb_len: got %0d want 2", sl); end
        n_vec++; if (fs != 2) begin n_err++; $display("FAIL early_stb_start: got %0d want 2", fs); end
        n_vec++; if (cyc != 5) begin n_err++; $display("FAIL early_latency: got %0d want 5", cyc); end
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL early_timeout: got %b want 0", to); end
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc, sl, fs;
        logic [3:0] d;
        logic [33:0] cw;
        logic to;
        logic [37:0] e;
        req_cmd[33:0] = 34'h0CAFE0001;
        req = 4'b0001;
        exp_q.push_back({4'b0001, 34'h0CAFE0001});
        run_cmd(2, 40, cyc, sl, fs, d, cw, to);
        e = exp_q.pop_front();
        n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL to_done: got %b want %b", d, e[37:34]); end
        n_vec++; if (cyc != 12) begin n_err++; $display("FAIL to_latency: got %0d want 12", cyc); end
        n_vec++; if (to !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b want 1", to); end
        n_vec++; if (timeout_sticky !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", timeout_sticky); end
        req = 4'b0;
        @(negedge clk);
        n_vec++; if ({timeout, timeout_sticky} !== 2'b01) begin n_err++; $display("FAIL to_after: got %b want 01", {timeout, timeout_sticky}); end
        req_cmd[34*1 +: 34] = 34'h0BEEF0002;
        req = 4'b0010;
        exp_q.push_back({4'b0010, 34'h0BEEF0002});
        run_cmd(0, 40, cyc, sl, fs, d, cw, to);
        e = exp_q.pop_front();
        n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL to_next_done: got %b want %b", d, e[37:34]); end
        n_vec++; if (cw !== e[33:0]) begin n_err++; $display("FAIL to_next_cmd: got %h want %h", cw, e[33:0]); end
        n_vec++; if ({to, timeout_sticky} !== 2'b01) begin n_err++; $display("FAIL to_next_flags: got %b want 01", {to, timeout_sticky}); end
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stb();
        int cyc, sl, fs;
        logic [3:0] d;
        logic [33:0] cw;
        logic to;
        logic [37:0] e;
        logic seen;
        req_cmd[34*2 +: 34] = 34'h212345678;
        req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_stb) begin seen = 1'b1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL rst_mid_stb_seen: got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({o_stb, busy} !== 2'b00) begin n_err++; $display("FAIL rst_mid_stb_busy: got %b want 00", {o_stb, busy}); end
        n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_mid_grant: got %b want 0000", grant); end
        n_vec++; if (cmd_word !== 34'h0) begin n_err++; $display("FAIL rst_mid_cmd: got %h want 0", cmd_word); end
        n_vec++; if ({done, timeout_sticky} !== 5'b0) begin n_err++; $display("FAIL rst_mid_done_sticky: got %b want 00000", {done, timeout_sticky}); end
        rst = 1'b0;
        exp_q.push_back({4'b0100, 34'h212345678});
        run_cmd(0, 40, cyc, sl, fs, d, cw, to);
        e = exp_q.pop_front();
        n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL rst_rearb_done: got %b want %b", d, e[37:34]); end
        n_vec++; if (cw !== e[33:0]) begin n_err++; $display("FAIL rst_rearb_cmd: got %h want %h", cw, e[33:0]); end
        n_vec++; if (cyc != 5) begin n_err++; $display("FAIL rst_rearb_latency: got %0d want 5", cyc); end
        req = 4'b0;
        @(negedge clk);
    endtask

`ifdef WB_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        int cyc, sl, fs;
        logic [3:0] d;
        logic [33:0] cw;
        logic to;
        logic [37:0] e;
        logic [3:0] oh;
        logic [33:0] c;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_cmd[34*i +: 34] = 34'h100000000 | 34'($urandom_range(0, 65535));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            oh = 4'b0001 << (k % 4);
            c  = req_cmd[34*(k % 4) +: 34];
            exp_q.push_back({oh, c});
            run_cmd(0, 40, cyc, sl, fs, d, cw, to);
            e = exp_q.pop_front();
            n_vec++; if (d !== e[37:34]) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", k, d, e[37:34]); end
            n_vec++; if (cw !== e[33:0]) begin n_err++; $display("FAIL rr_cmd%0d: got %h want %h", k, cw, e[33:0]); end
            @(negedge clk);
        end
        req = 4'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_early_ack();
        test_timeout();
        test_reset_mid_stb();
`ifdef WB_ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
